// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states and the
// IF/ID register update operations with their priority resolution.
package if_fetch_pkg;

  localparam int IF_ADDR_W   = 32;
  localparam int IF_DATA_W   = 32;
  localparam int IF_STALL_W  = 6;
  localparam int IF_STALL_IF = 1;
  localparam int IF_STALL_ID = 2;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2,
    IF_DROP = 2'd3
  } if_state_e;

  typedef enum logic [1:0] {
    IFID_CLEAR  = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_KEEP   = 2'd2,
    IFID_LOAD   = 2'd3
  } ifid_op_e;

  // Flush beats bubble beats hold beats a new load.
  function automatic ifid_op_e ifid_op(input logic clear, input logic stall_if,
                                       input logic stall_id, input logic load);
    if (clear)                    return IFID_CLEAR;
    else if (stall_if && !stall_id) return IFID_BUBBLE;
    else if (stall_if)            return IFID_KEEP;
    else if (load)                return IFID_LOAD;
    return IFID_KEEP;
  endfunction

endpackage

// File: rtl/if_fetch_id_reg.sv
// IF/ID pipeline register: clears on reset/flush, bubbles when IF stalls but
// ID does not, holds when both stall, otherwise takes a presented load.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_if_i,
  input  logic              stall_id_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic [DATA_W-1:0] load_inst_i,
  input  logic              load_adel_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_excp_adel_o
);

  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic              id_adel_q, id_adel_d;

  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_adel_d = id_adel_q;
    case (ifid_op(flush_i, stall_if_i, stall_id_i, load_i))
      IFID_CLEAR, IFID_BUBBLE: begin
        id_pc_d   = '0;
        id_inst_d = NOP_INST;
        id_adel_d = 1'b0;
      end
      IFID_LOAD: begin
        id_pc_d   = load_pc_i;
        id_inst_d = load_inst_i;
        id_adel_d = load_adel_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
      id_adel_q <= 1'b0;
    end else begin
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_adel_q <= id_adel_d;
    end
  end

  assign id_pc_o        = id_pc_q;
  assign id_inst_o      = id_inst_q;
  assign id_excp_adel_o = id_adel_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one-in-flight req/gnt/rvalid fetch feeding IF/ID.
// Define IF_MISALIGN_EXC_EN to raise address-error on pc[1:0]!=0 instead of aligning.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc,
  input  logic                  ce,
  input  logic [IF_STALL_W-1:0] stall,
  input  logic                  flush,
  output logic                  stallreq_if,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_W-1:0]     imem_rdata,
  output logic [ADDR_W-1:0]     id_pc,
  output logic [DATA_W-1:0]     id_inst,
  output logic                  id_excp_adel
);

`ifdef IF_MISALIGN_EXC_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;

  logic              load;
  logic [ADDR_W-1:0] load_pc;
  logic [DATA_W-1:0] load_inst;
  logic              load_adel;
  logic              stall_if;
  logic              misaligned;
  logic              unused_stall;

  assign stall_if     = stall[IF_STALL_IF];
  assign misaligned   = MISALIGN_EN && (pc[1:0] != 2'b00);
  assign imem_addr    = {pc[ADDR_W-1:2], 2'b00};
  assign unused_stall = ^{stall[5:3], stall[0]};

  always_comb begin
    state_d     = state_q;
    issued_pc_d = issued_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    imem_req    = 1'b0;
    stallreq_if = 1'b0;
    load        = 1'b0;
    load_pc     = '0;
    load_inst   = NOP_INST;
    load_adel   = 1'b0;
    case (state_q)
      IF_IDLE: begin
        if (ce && !flush) begin
          if (misaligned) begin
            // Faulting fetch goes straight to decode as a flagged NOP.
            load      = 1'b1;
            load_pc   = pc;
            load_adel = 1'b1;
          end else begin
            imem_req    = 1'b1;
            stallreq_if = 1'b1;
            if (imem_gnt) begin
              issued_pc_d = imem_addr;
              state_d     = IF_WAIT;
            end
          end
        end
      end
      IF_WAIT: begin
        stallreq_if = !imem_rvalid;
        if (imem_rvalid) begin
          if (flush) begin
            state_d = IF_IDLE;
          end else if (!stall_if) begin
            load      = 1'b1;
            load_pc   = issued_pc_q;
            load_inst = imem_rdata;
            state_d   = IF_IDLE;
          end else begin
            hold_pc_d   = issued_pc_q;
            hold_inst_d = imem_rdata;
            state_d     = IF_HOLD;
          end
        end else if (flush) begin
          state_d = IF_DROP;
        end
      end
      IF_HOLD: begin
        if (flush) begin
          state_d = IF_IDLE;
        end else if (!stall_if) begin
          load      = 1'b1;
          load_pc   = hold_pc_q;
          load_inst = hold_inst_q;
          state_d   = IF_IDLE;
        end
      end
      IF_DROP: begin
        // The flushed request still owes us one response; eat it.
        stallreq_if = 1'b1;
        if (imem_rvalid) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      issued_pc_q <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      issued_pc_q <= issued_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .stall_if_i     (stall_if),
    .stall_id_i     (stall[IF_STALL_ID]),
    .load_i         (load),
    .load_pc_i      (load_pc),
    .load_inst_i    (load_inst),
    .load_adel_i    (load_adel),
    .id_pc_o        (id_pc),
    .id_inst_o      (id_inst),
    .id_excp_adel_o (id_excp_adel)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: memory responder plus a transaction-level
// model of the pending fetch, held word and IF/ID contents.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_MISALIGN_EXC_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_excp_adel;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall        (stall),
    .flush        (flush),
    .stallreq_if  (stallreq_if),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_excp_adel (id_excp_adel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fetch bookkeeping in plain flags.
  bit          m_out, m_drop, m_held, m_adel, m_last_stq;
  logic [31:0] m_issued, m_hpc, m_hinst, m_pc, m_inst;

  // Memory responder
  bit          r_pend;
  int          r_cnt;
  logic [31:0] r_data;
  int          lat_sel    = -1;
  bit          data_fixed = 1'b0;
  logic [31:0] data_sel   = '0;

  bit          last_req;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit ce_v, input logic [31:0] pc_v, input logic [5:0] st_v,
                      input bit fl_v, input bit gnt_v, input bit spur_v);
    bit          aligned, idle, e_req, e_stq, mis_load, rv, ld, ladel;
    logic [31:0] rd, lpc, linst;
    @(negedge clk);
    ce = ce_v; pc = pc_v; stall = st_v; flush = fl_v; imem_gnt = 1'b0;
    rv = 1'b0;
    rd = $urandom;
    if (r_pend && r_cnt == 0) begin
      rv = 1'b1;
      rd = r_data;
    end else if (spur_v && !r_pend) begin
      rv = 1'b1;
    end
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
    aligned  = !MIS || (pc_v[1:0] == 2'b00);
    idle     = !m_out && !m_held;
    e_req    = idle && ce_v && !fl_v && aligned;
    mis_load = idle && ce_v && !fl_v && !aligned;
    e_stq    = e_req || (m_out && (m_drop || !rv));
    if (!rst) begin
      chk("imem_req", imem_req, e_req);
      chk("stallreq_if", stallreq_if, e_stq);
      if (e_req) chk("imem_addr", imem_addr, {pc_v[31:2], 2'b00});
    end
    last_req   = imem_req;
    last_addr  = imem_addr;
    imem_gnt   = imem_req && gnt_v;
    m_last_stq = e_stq;
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_drop = 0; m_held = 0;
      m_pc = '0; m_inst = NOP; m_adel = 0;
    end else begin
      ld = 0; lpc = '0; linst = NOP; ladel = 0;
      if (m_out && !m_drop && rv && !st_v[1] && !fl_v) begin
        ld = 1; lpc = m_issued; linst = rd;
      end else if (m_held && !st_v[1] && !fl_v) begin
        ld = 1; lpc = m_hpc; linst = m_hinst;
      end else if (mis_load) begin
        ld = 1; lpc = pc_v; ladel = 1;
      end
      if (fl_v || (st_v[1] && !st_v[2])) begin
        m_pc = '0; m_inst = NOP; m_adel = 0;
      end else if (!st_v[1] && ld) begin
        m_pc = lpc; m_inst = linst; m_adel = ladel;
      end
      if (m_out) begin
        if (rv) begin
          if (!m_drop && !fl_v && st_v[1]) begin
            m_held = 1; m_hpc = m_issued; m_hinst = rd;
          end
          m_out = 0; m_drop = 0;
        end else if (fl_v) begin
          m_drop = 1;
        end
      end else if (m_held) begin
        if (fl_v || !st_v[1]) m_held = 0;
      end else if (e_req && imem_gnt) begin
        m_out = 1; m_issued = {pc_v[31:2], 2'b00};
      end
    end
    if (rv && r_pend && r_cnt == 0) r_pend = 0;
    else if (r_pend) r_cnt--;
    if (imem_gnt) begin
      r_pend = 1;
      r_cnt  = (lat_sel >= 0) ? lat_sel : int'($urandom_range(0, 2));
      r_data = data_fixed ? data_sel : 32'($urandom);
    end
    #1;
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("id_excp_adel", id_excp_adel, m_adel);
  endtask

  logic [31:0] cur_pc;
  logic [5:0]  st_r;
  int          sel;

  initial begin
    rst = 1'b1; ce = 0; pc = '0; stall = '0; flush = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    r_pend = 0; r_cnt = 0; r_data = '0;
    m_out = 0; m_drop = 0; m_held = 0; m_adel = 0; m_last_stq = 0;
    m_issued = '0; m_hpc = '0; m_hinst = '0; m_pc = '0; m_inst = NOP;
    step(0, 32'h0, 6'b0, 0, 0, 0);
    step(0, 32'h0, 6'b0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_adel", id_excp_adel, 1'b0);
    step(0, 32'h0, 6'b0, 0, 0, 0);
    chk("rst_req", last_req, 1'b0);

    // zero-wait fetch
    data_fixed = 1; lat_sel = 0; data_sel = 32'h3C01_0001;
    step(1, 32'h100, 6'b0, 0, 1, 0);
    chk("t1_addr", last_addr, 32'h100);
    step(0, 32'h100, 6'b0, 0, 0, 0);
    chk("t1_id_pc", id_pc, 32'h100);
    chk("t1_id_inst", id_inst, 32'h3C01_0001);
    $display("[TB] fetch pc=%h inst=%h", id_pc, id_inst);

    // grant withheld, slow response
    lat_sel = 1; data_sel = 32'h2402_0005;
    repeat (3) step(1, 32'h200, 6'b0, 0, 0, 0);
    step(1, 32'h200, 6'b0, 0, 1, 0);
    step(0, 32'h200, 6'b0, 0, 0, 0);
    chk("t2_no_early_load", id_inst, 32'h3C01_0001);
    step(0, 32'h200, 6'b0, 0, 0, 0);
    chk("t2_id_pc", id_pc, 32'h200);
    chk("t2_id_inst", id_inst, 32'h2402_0005);
    $display("[TB] fetch pc=%h inst=%h", id_pc, id_inst);

    // response during stall goes to the hold register
    lat_sel = 0; data_sel = 32'h8C43_0004;
    step(1, 32'h300, 6'b0, 0, 1, 0);
    step(0, 32'h300, 6'b000111, 0, 0, 0);
    chk("t3_held_inst", id_inst, 32'h2402_0005);
    step(0, 32'h300, 6'b000111, 0, 0, 0);
    step(0, 32'h300, 6'b0, 0, 0, 0);
    chk("t3_id_pc", id_pc, 32'h300);
    chk("t3_id_inst", id_inst, 32'h8C43_0004);
    $display("[TB] fetch pc=%h inst=%h", id_pc, id_inst);

    // flush while waiting; the late word is dropped
    lat_sel = 1; data_sel = 32'hDEAD_BEEF;
    step(1, 32'h400, 6'b0, 0, 1, 0);
    step(1, 32'h400, 6'b0, 1, 0, 0);
    chk("t4_flush_inst", id_inst, NOP);
    step(1, 32'h400, 6'b0, 0, 0, 0);
    chk("t4_drop_inst", id_inst, NOP);
    lat_sel = 0; data_sel = 32'h0085_1020;
    step(1, 32'h400, 6'b0, 0, 1, 0);
    chk("t4_refetch_req", last_req, 1'b1);
    chk("t4_refetch_addr", last_addr, 32'h400);
    step(0, 32'h400, 6'b0, 0, 0, 0);
    chk("t4_id_inst", id_inst, 32'h0085_1020);
    $display("[TB] fetch pc=%h inst=%h (after flush)", id_pc, id_inst);

    // bubble while idle
    repeat (2) begin
      step(0, 32'h0, 6'b000011, 0, 0, 0);
      chk("t5_bubble_inst", id_inst, NOP);
      chk("t5_bubble_pc", id_pc, 32'h0);
    end
    $display("[TB] bubble pc=%h inst=%h", id_pc, id_inst);

`ifdef IF_MISALIGN_EXC_EN
    step(1, 32'h102, 6'b0, 0, 1, 0);
    chk("t6_no_req", last_req, 1'b0);
    chk("t6_id_pc", id_pc, 32'h102);
    chk("t6_id_adel", id_excp_adel, 1'b1);
    chk("t6_id_inst", id_inst, NOP);
    $display("[TB] misaligned pc=%h adel=%0d", id_pc, id_excp_adel);
`endif

    // reset in mid-transaction; the late response must be ignored
    lat_sel = 2; data_sel = 32'h1234_5678;
    step(1, 32'h500, 6'b0, 0, 1, 0);
    rst = 1'b1;
    step(0, 32'h500, 6'b0, 0, 0, 0);
    rst = 1'b0;
    repeat (4) step(0, 32'h500, 6'b0, 0, 0, 0);
    chk("t7_late_ignored", id_inst, NOP);
    $display("[TB] reset mid-fetch pc=%h inst=%h", id_pc, id_inst);

    // randomized traffic
    lat_sel = -1; data_fixed = 0;
    cur_pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      if (!m_last_stq && $urandom_range(0, 3) == 0) begin
        cur_pc = $urandom & 32'hFFFF_FFFC;
        if (MIS && $urandom_range(0, 7) == 0) cur_pc[1:0] = 2'($urandom_range(1, 3));
      end
      sel = int'($urandom_range(0, 9));
      st_r = (sel < 6) ? 6'b000000 : (sel < 8) ? 6'b000111 : (sel == 8) ? 6'b000011 : 6'b001111;
      step($urandom_range(0, 9) < 8, cur_pc, st_r, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
